// File: rtl/fsub_seq.sv
// fsub_seq: multi-cycle single-precision subtractor, result = op_a - op_b.
// The subtrahend's sign is flipped on accept, so the datapath is an adder of
// magnitudes with truncation and no special-value handling.
// Alignment is one bit per ALIGN cycle by default. Defining FSUB_SEQ_BARREL_EN
// replaces that with a single-cycle barrel shift.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for operands; in_ready high; bypass cases resolved here
// S_ALIGN | shift smaller mantissa right while the shift down-counter runs
// S_ADD   | add or subtract the aligned mantissas
// S_NORM  | one normalise step per cycle until the result is written
// S_DONE  | out_valid high; result held until out_ready
module fsub_seq #(
    parameter int ALIGN_LIMIT = 23
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ALIGN = 3'd1,
        S_ADD   = 3'd2,
        S_NORM  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t      state, state_nx;

    logic [25:0] m_max;
    logic [25:0] m_min;
    logic [7:0]  cnt;
    logic [7:0]  e_q;
    logic        sign_q;
    logic        eff_sub_q;

    logic [31:0] b_neg;
    logic        a_zero;
    logic        b_zero;
    logic        a_is_max;
    logic [31:0] max_w;
    logic [31:0] min_w;
    logic [7:0]  exp_diff;
    logic        far;
    logic        bypass;
    logic        norm_final;

    // Operand decode on the live inputs; only consumed on the accept edge.
    always_comb begin
        b_neg    = {~op_b[31], op_b[30:0]};
        a_zero   = (op_a[30:0] == 31'd0);
        b_zero   = (b_neg[30:0] == 31'd0);
        a_is_max = (op_a[30:23] > b_neg[30:23]) ||
                   ((op_a[30:23] == b_neg[30:23]) && (op_a[22:0] > b_neg[22:0]));
        max_w    = a_is_max ? op_a  : b_neg;
        min_w    = a_is_max ? b_neg : op_a;
        exp_diff = max_w[30:23] - min_w[30:23];
        far      = int'(exp_diff) > ALIGN_LIMIT;
        bypass   = a_zero || b_zero || far;
    end

    // A NORM cycle is final when it writes the result instead of shifting.
    always_comb begin
        norm_final = 1'b0;
        if (m_max == 26'd0)
            norm_final = 1'b1;
        else if (m_max[25])
            norm_final = (e_q == 8'hFF);
        else if (!m_max[24])
            norm_final = (e_q <= 8'd1);
        else
            norm_final = 1'b1;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    state_nx = bypass ? S_DONE : S_ALIGN;
            end
            S_ALIGN: begin
`ifdef FSUB_SEQ_BARREL_EN
                state_nx = S_ADD;
`else
                if (cnt == 8'd0)
                    state_nx = S_ADD;
`endif
            end
            S_ADD: begin
                state_nx = S_NORM;
            end
            S_NORM: begin
                if (norm_final)
                    state_nx = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Datapath: operand capture, alignment, add, normalise, result register.
    // m_max doubles as the sum register from ADD onwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_max     <= '0;
            m_min     <= '0;
            cnt       <= '0;
            e_q       <= '0;
            sign_q    <= 1'b0;
            eff_sub_q <= 1'b0;
            result    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (a_zero)
                            result <= b_neg;
                        else if (b_zero)
                            result <= op_a;
                        else if (far)
                            result <= max_w;
                        else begin
                            m_max     <= {2'b01, max_w[22:0], 1'b0};
                            m_min     <= {2'b01, min_w[22:0], 1'b0};
                            cnt       <= exp_diff;
                            e_q       <= max_w[30:23];
                            sign_q    <= max_w[31];
                            eff_sub_q <= max_w[31] ^ min_w[31];
                        end
                    end
                end
                S_ALIGN: begin
`ifdef FSUB_SEQ_BARREL_EN
                    m_min <= m_min >> cnt;
                    cnt   <= 8'd0;
`else
                    if (cnt != 8'd0) begin
                        m_min <= m_min >> 1;
                        cnt   <= cnt - 8'd1;
                    end
`endif
                end
                S_ADD: begin
                    // After alignment m_max >= m_min, so the difference never wraps.
                    if (eff_sub_q)
                        m_max <= m_max - m_min;
                    else
                        m_max <= m_max + m_min;
                end
                S_NORM: begin
                    if (m_max == 26'd0)
                        result <= 32'h0000_0000;
                    else if (m_max[25]) begin
                        if (e_q == 8'hFF)
                            result <= {sign_q, 8'hFF, 23'h7F_FFFF};
                        else begin
                            m_max <= m_max >> 1;
                            e_q   <= e_q + 8'd1;
                        end
                    end else if (!m_max[24]) begin
                        if (e_q <= 8'd1)
                            result <= {sign_q, 31'd0};
                        else begin
                            m_max <= m_max << 1;
                            e_q   <= e_q - 8'd1;
                        end
                    end else
                        result <= {sign_q, e_q, m_max[23:1]};
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fsub_seq.sv
// tb_fsub_seq: directed vectors with hand-computed results and completion edges
// for fsub_seq. Completion edge counts from the accept edge (edge 0).
module tb_fsub_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;

    int n_vec  = 0;
    int n_miss = 0;

    fsub_seq #(.ALIGN_LIMIT(23)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Completion edge of the normal path for exponent difference d and n NORM shifts.
    function automatic int done_edge(input int d, input int n);
`ifdef FSUB_SEQ_BARREL_EN
        return n + 3;
`else
        return d + n + 3;
`endif
    endfunction

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input int exp_edge, input int hold);
        int edge_n;
        logic seen;
        logic [31:0] held;
        @(negedge clk);
        op_a     = a;
        op_b     = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op_a     = 32'hDEAD_BEEF;
        op_b     = 32'h1234_5678;
        edge_n   = 0;
        seen     = out_valid;
        while (!seen && edge_n < 200) begin
            @(posedge clk);
            #1;
            edge_n++;
            seen = out_valid;
        end
        check_val($sformatf("%s/done", tag), {31'd0, seen}, 32'd1);
        check_val($sformatf("%s/edge", tag), 32'(edge_n), 32'(exp_edge));
        check_val($sformatf("%s/res", tag), result, exp_res);
        held = result;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            op_a = $urandom;
            op_b = $urandom;
            @(posedge clk);
            #1;
            check_val($sformatf("%s/hold_res%0d", tag, i), result, held);
            check_val($sformatf("%s/hold_rdy%0d", tag, i), {31'd0, in_ready}, 32'd0);
            check_val($sformatf("%s/hold_vld%0d", tag, i), {31'd0, out_valid}, 32'd1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_val($sformatf("%s/post_vld", tag), {31'd0, out_valid}, 32'd0);
        check_val($sformatf("%s/post_rdy", tag), {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op_a      = '0;
        op_b      = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst/in_ready", {31'd0, in_ready}, 32'd1);
        check_val("rst/out_valid", {31'd0, out_valid}, 32'd0);
        check_val("rst/result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("basic",   32'h4040_0000, 32'h3F80_0000, 32'h4000_0000, done_edge(1, 0), 0);
        run_op("equal",   32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000, done_edge(0, 0), 0);
        run_op("carry",   32'h3F80_0000, 32'hBF80_0000, 32'h4000_0000, done_edge(0, 1), 0);
        run_op("far30",   32'h3F80_0000, 32'h3080_0000, 32'h3F80_0000, 0, 0);
        run_op("a_zero",  32'h0000_0000, 32'h4000_0000, 32'hC000_0000, 0, 0);
        run_op("b_zero",  32'h40A0_0000, 32'h8000_0000, 32'h40A0_0000, 0, 0);
        run_op("sat",     32'h7F7F_FFFF, 32'hFF7F_FFFF, 32'h7FFF_FFFF, done_edge(0, 1), 0);
        run_op("lshift",  32'h3F80_0000, 32'h3F40_0000, 32'h3E80_0000, done_edge(1, 2), 0);
        run_op("neg",     32'h3F80_0000, 32'h4040_0000, 32'hC000_0000, done_edge(1, 0), 0);
        run_op("d23",     32'h3F80_0000, 32'h3400_0000, 32'h3F7F_FFFE, done_edge(23, 1), 0);
        run_op("d24",     32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000, 0, 0);
        run_op("flush",   32'h0080_0000, 32'h00C0_0000, 32'h8000_0000, done_edge(0, 0), 0);
        run_op("bp",      32'h4040_0000, 32'h3F80_0000, 32'h4000_0000, done_edge(1, 0), 10);

        // Abort an operation while it is aligning.
        @(negedge clk);
        op_a     = 32'h3F80_0000;
        op_b     = 32'h3400_0000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_val("abort/in_align", {31'd0, in_ready | out_valid}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("abort/out_valid", {31'd0, out_valid}, 32'd0);
        check_val("abort/in_ready", {31'd0, in_ready}, 32'd1);
        check_val("abort/result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check_val("abort/no_out", {31'd0, out_valid}, 32'd0);

        run_op("recover", 32'h4040_0000, 32'h3F80_0000, 32'h4000_0000, done_edge(1, 0), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
